// File: rtl/bubble_sort_seq.sv
// rtl/bubble_sort_seq.sv - sequential bubble-sort engine, one compare-and-swap per clock
// Build option: define SORT_DESCEND_EN for largest-first output order.
module bubble_sort_seq #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    i_q;

    logic [PW-1:0]    i_d;
    logic [WIDTH-1:0] lo_val;
    logic [WIDTH-1:0] hi_val;
    logic             swap;
    logic             pass_end;

    assign i_d    = i_q + 1'b1;
    assign lo_val = mem_q[i_q];
    assign hi_val = mem_q[i_d];

    // Strict comparison keeps equal elements in place, which makes the sort stable.
`ifdef SORT_DESCEND_EN
    assign swap = lo_val < hi_val;
`else
    assign swap = lo_val > hi_val;
`endif

    assign pass_end = (i_q == (LAST_PASS - p_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            p_q      <= '0;
            i_q      <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        mem_q[wr_ptr_q] <= in_data;
                        if (wr_ptr_q == LAST_IDX) begin
                            wr_ptr_q <= '0;
                            p_q      <= '0;
                            i_q      <= '0;
                            state_q  <= S_SORT;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (swap) begin
                        mem_q[i_q] <= hi_val;
                        mem_q[i_d] <= lo_val;
                    end
                    // No early exit: every pass runs so the sort time is fixed.
                    if (pass_end) begin
                        i_q <= '0;
                        if (p_q == LAST_PASS) begin
                            rd_ptr_q <= '0;
                            state_q  <= S_DRAIN;
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end else begin
                        i_q <= i_d;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr_q == LAST_IDX) begin
                            rd_ptr_q <= '0;
                            state_q  <= S_LOAD;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_SORT);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = (state_q == S_DRAIN) && (rd_ptr_q == LAST_IDX);
    assign out_data  = (state_q == S_DRAIN) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// tb/tb_bubble_sort_seq.sv - directed bench for bubble_sort_seq (DEPTH=8 and exhaustive DEPTH=3)
module tb_bubble_sort_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [2:0] in_data, out_data;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
    logic [2:0] in_data3, out_data3;

    int errors = 0;
    int checks = 0;

    typedef logic [2:0] vec_t [8];
    vec_t v_rev, v_dup, v_two, v_mix;
    vec_t e_rev, e_dup, e_two, e_mix;

    bubble_sort_seq #(.WIDTH(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    bubble_sort_seq #(.WIDTH(3), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_last(out_last3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input vec_t v, input int gap);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    check("busy_in_gap", busy, 0);
                    @(negedge clk);
                end
            end
            send(v[k]);
        end
    endtask

    task automatic sort_wait(input int exp_c);
        int n = 0;
        while (busy && n < 200) begin
            check("in_ready_in_sort", in_ready, 0);
            @(negedge clk);
            n++;
        end
        check("busy_cycles", n, exp_c);
        check("out_valid_after_sort", out_valid, 1);
        check("in_ready_in_drain", in_ready, 0);
    endtask

    task automatic drain(input vec_t e, input bit toggle);
        int k = 0;
        int cyc = 0;
        while (k < 8 && cyc < 100) begin
            out_ready = !toggle || ((cyc % 2) == 0);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, e[k]);
            check("out_last", out_last, (k == 7));
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_done", k, 8);
        check("turnaround_in_ready", in_ready, 1);
        check("turnaround_out_valid", out_valid, 0);
    endtask

    task automatic exhaustive3();
        int a, b, c, lo, hi, mid, n;
        int e [3];
        int s [3];
        for (int t = 0; t < 512; t++) begin
            a = (t >> 6) & 7;
            b = (t >> 3) & 7;
            c = t & 7;
            s[0] = a; s[1] = b; s[2] = c;
            lo = (a < b) ? a : b;
            lo = (lo < c) ? lo : c;
            hi = (a > b) ? a : b;
            hi = (hi > c) ? hi : c;
            mid = a + b + c - lo - hi;
`ifdef SORT_DESCEND_EN
            e[0] = hi; e[1] = mid; e[2] = lo;
`else
            e[0] = lo; e[1] = mid; e[2] = hi;
`endif
            for (int j = 0; j < 3; j++) begin
                check("x3_in_ready", in_ready3, 1);
                in_valid3 = 1'b1;
                in_data3  = 3'(s[j]);
                @(negedge clk);
            end
            in_valid3 = 1'b0;
            n = 0;
            while (busy3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("x3_busy_cycles", n, 3);
            out_ready3 = 1'b1;
            for (int j = 0; j < 3; j++) begin
                check("x3_out_valid", out_valid3, 1);
                check("x3_out_data", out_data3, e[j]);
                check("x3_out_last", out_last3, (j == 2));
                @(negedge clk);
            end
            out_ready3 = 1'b0;
        end
        check("x3_final_in_ready", in_ready3, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_rev = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        v_dup = '{3'd3, 3'd1, 3'd3, 3'd0, 3'd7, 3'd1, 3'd5, 3'd0};
        v_two = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        v_mix = '{3'd0, 3'd5, 3'd2, 3'd7, 3'd1, 3'd1, 3'd6, 3'd3};
        e_two = v_two;
`ifdef SORT_DESCEND_EN
        e_rev = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        e_dup = '{3'd7, 3'd5, 3'd3, 3'd3, 3'd1, 3'd1, 3'd0, 3'd0};
        e_mix = '{3'd7, 3'd6, 3'd5, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0};
`else
        e_rev = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        e_dup = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd5, 3'd7};
        e_mix = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
`endif
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        load(v_rev, 0);
        sort_wait(28);
        drain(e_rev, 1'b0);

        load(v_dup, 0);
        sort_wait(28);
        drain(e_dup, 1'b1);

        load(v_rev, 3);
        sort_wait(28);
        drain(e_rev, 1'b0);

        load(v_dup, 0);
        repeat (9) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        @(negedge clk);
        check("abort_hold_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load(v_two, 0);
        sort_wait(28);
        drain(e_two, 1'b0);

        load(v_mix, 0);
        sort_wait(28);
        drain(e_mix, 1'b1);

        exhaustive3();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bubble_sort_seq.md
# bubble_sort_seq

Sequential bubble-sort engine for the sorting subsystem. It accepts DEPTH unsigned words one at a time over a valid/ready input stream. It sorts them in place with one compare-and-swap per clock, then streams the sorted words out over a valid/ready output stream. It sits between the stimulus source and the result checker, and replaces the single-cycle three-input sorter wherever the element count exceeds three.

## Interface
- WIDTH, 3, bit width of each element (≥1)
- DEPTH, 8, number of elements per sort job (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept an element this cycle
- in_data  input  WIDTH  unsigned element to load
- out_valid  output  1  out_data holds a sorted element
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  sorted element
- out_last  output  1  out_data is the final element of the job
- busy  output  1  high while in SORT state

## Operation
- Storage: DEPTH×WIDTH register array mem[0..DEPTH-1].
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide.
- Counters: pass counter p and index counter i.
- States:
  - LOAD: in_ready=1. Each in_valid&&in_ready writes mem[wr_ptr] and increments wr_ptr. The DEPTH-th accepted element moves the state to SORT and clears wr_ptr, p and i.
  - SORT: busy=1, in_ready=0, out_valid=0.
    - Each cycle compares mem[i] with mem[i+1] as unsigned values and swaps them if mem[i] > mem[i+1].
    - Equal values are never swapped, so the sort is stable.
    - i runs 0..DEPTH-2-p. At the end of a pass, i returns to 0 and p increments.
    - After pass p=DEPTH-2 completes, the state moves to DRAIN with rd_ptr=0.
    - There is no early exit: SORT always lasts exactly C = DEPTH*(DEPTH-1)/2 cycles.
  - DRAIN: out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==DEPTH-1).
    - Each out_valid&&out_ready increments rd_ptr.
    - Acceptance of the element with out_last=1 moves the state to LOAD.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- in_ready, out_valid, out_last and busy decode combinationally from registered state and pointers.
- out_data is driven from the mem array through a registered-pointer mux. Outside DRAIN it is 0.

## Timing
- Reset (rst low, asynchronous):
  - state=LOAD; all pointers and counters are 0; mem is cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Load: at most one element per cycle, with zero bubbles under continuous in_valid. DEPTH elements take DEPTH cycles minimum.
- Sort latency: the last input handshake occurs in cycle T. busy is high in cycles T+1..T+C. out_valid first rises in cycle T+C+1. For the default parameters, C=28.
- Drain: one element per cycle when out_ready is held high.
  - With out_ready low, out_data and out_last hold stable and out_valid stays high.
- Turnaround: the cycle after the last output handshake, in_ready=1. A new element is accepted in that cycle if in_valid is high.
- Reset mid-job, in any state: the partial job is discarded and the block returns to the reset values above immediately. No output handshake occurs for the aborted job.
- The input and output streams never overlap: in_ready and out_valid are never both 1.

## Configuration
- SORT_DESCEND_EN:
  - Defined: the swap condition becomes mem[i] < mem[i+1], and the output order is largest first. Equal values are still not swapped.
  - Undefined (default): ascending order, smallest first.
  - Timing, latency and handshakes are identical in both builds.

## Test plan
- Reverse load, default parameters: in_data 7,6,5,4,3,2,1,0 back-to-back, out_ready=1.
  - busy high for exactly 28 cycles.
  - Outputs 0,1,2,3,4,5,6,7 on consecutive cycles, with out_last only with 7.
- Duplicates plus backpressure: input 3,1,3,0,7,1,5,0, with out_ready toggling 1,0,1,0.
  - Outputs 0,0,1,1,3,3,5,7.
  - Each value holds while out_ready=0.
- Input gaps: in_valid deasserted for 3 cycles between each element.
  - Sort starts only after the 8th handshake.
  - Results match the same data sent without gaps.
- Reset mid-operation: assert rst low at SORT cycle 10, release, then load 2,2,2,2,2,2,2,2.
  - in_ready=1 and out_valid=0 during reset.
  - Eight 2s are output; no residue from the aborted job appears.
- Exhaustive check, WIDTH=3, DEPTH=3: load all 512 (a,b,c) combinations in sequence.
  - C=3 SORT cycles per job.
  - Each output triple matches the sorted triple.
  - The next load starts the cycle after out_last.
- SORT_DESCEND_EN defined: input 0,5,2,7,1,1,6,3 → outputs 7,6,5,3,2,1,1,0, with latency unchanged.
